// File: rtl/sprite_animator.sv
// Positioned, animated, mirrorable sprite pixel engine driving an external synchronous ROM.
// Fixed 3-cycle latency from DrawX/DrawY to pixel_index/pixel_valid.
//
// state | meaning
// RUN   | animation advances on frame_tick while anim_en=1
// DONE  | non-looping animation parked on its last frame
module sprite_animator #(
    parameter int SPR_W           = 50,
    parameter int SPR_H           = 64,
    parameter int NUM_FRAMES      = 4,
    parameter int IDX_W           = 3,
    parameter int ADDR_W          = 14,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FRAME_HOLD      = 8,
    parameter int FRAME_W         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              mirror,
    input  logic              anim_en,
    input  logic              anim_loop,
    input  logic              anim_restart,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pixel_index,
    output logic              pixel_valid,
    output logic [FRAME_W-1:0] anim_frame,
    output logic              anim_done
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPR_W * SPR_H);

    logic [0:0]        state;
    logic [HOLD_W-1:0] hold;
    logic [9:0]        shadow_x;
    logic [9:0]        shadow_y;
    logic              shadow_mirror;

    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              hit;
    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [9:0]        col;
    logic [ADDR_W-1:0] addr_calc;

    logic              hit_d1;
    logic              hit_d2;
    logic              blank_d1;
    logic              blank_d2;
    logic              opaque;

    assign anim_done = (state == ST_DONE);

    // Position and mirror are only sampled on the tick so a frame never tears.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state         <= ST_RUN;
            hold          <= '0;
            anim_frame    <= '0;
            shadow_x      <= '0;
            shadow_y      <= '0;
            shadow_mirror <= 1'b0;
        end else begin
            if (frame_tick) begin
                shadow_x      <= pos_x;
                shadow_y      <= pos_y;
                shadow_mirror <= mirror;
            end
            if (anim_restart) begin
                state      <= ST_RUN;
                hold       <= '0;
                anim_frame <= '0;
            end else if (frame_tick && anim_en && state == ST_RUN) begin
                if (hold == HOLD_W'(FRAME_HOLD - 1)) begin
                    hold <= '0;
                    if (anim_frame == FRAME_W'(NUM_FRAMES - 1)) begin
                        if (anim_loop) begin
                            anim_frame <= '0;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        anim_frame <= anim_frame + FRAME_W'(1);
                    end
                end else begin
                    hold <= hold + HOLD_W'(1);
                end
            end
        end
    end

    // 11-bit edges keep sprites near the right/bottom border from wrapping to 0.
    assign x_end = {1'b0, shadow_x} + 11'(SPR_W);
    assign y_end = {1'b0, shadow_y} + 11'(SPR_H);
    assign hit   = ({1'b0, DrawX} >= {1'b0, shadow_x}) && ({1'b0, DrawX} < x_end) &&
                   ({1'b0, DrawY} >= {1'b0, shadow_y}) && ({1'b0, DrawY} < y_end);
    assign dx    = DrawX - shadow_x;
    assign dy    = DrawY - shadow_y;
    assign col   = shadow_mirror ? (10'(SPR_W - 1) - dx) : dx;
    assign addr_calc = ADDR_W'(anim_frame) * FRAME_SIZE
                     + ADDR_W'(dy) * ADDR_W'(SPR_W)
                     + ADDR_W'(col);

    assign opaque = (rom_q != IDX_W'(TRANSPARENT_IDX));

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_address <= '0;
            hit_d1      <= 1'b0;
            hit_d2      <= 1'b0;
            blank_d1    <= 1'b0;
            blank_d2    <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
        end else begin
            if (hit) begin
                rom_address <= addr_calc;
            end
            hit_d1      <= hit;
            blank_d1    <= blank;
            hit_d2      <= hit_d1;
            blank_d2    <= blank_d1;
            pixel_valid <= hit_d2 && blank_d2 && opaque;
            pixel_index <= (hit_d2 && blank_d2 && opaque) ? rom_q : '0;
        end
    end

endmodule
